// File: rtl/btn_pkg.sv
// Shared definitions for the push-button conditioning slice: channel FSM
// states, default timing constants and the counter width helper.
package btn_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HELD   = 2'd1,
        REPEAT = 2'd2
    } btn_state_t;

    localparam int DEF_N_BTN            = 2;
    localparam int DEF_DEBOUNCE_CYC     = 1000000;
    localparam int DEF_REPEAT_EN        = 0;
    localparam int DEF_REPEAT_DELAY_CYC = 50000000;
    localparam int DEF_REPEAT_RATE_CYC  = 20000000;

    // One spare bit above what the largest count needs.
    function automatic int cnt_width(input int max_val);
        return $clog2(max_val) + 1;
    endfunction

endpackage

// File: rtl/btn_channel.sv
// One button channel: two-flop synchronizer, glitch-resetting debounce
// counter and the press/hold/repeat FSM that produces one-cycle strobes.
module btn_channel
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYC     = DEF_DEBOUNCE_CYC,
    parameter int REPEAT_EN        = DEF_REPEAT_EN,
    parameter int REPEAT_DELAY_CYC = DEF_REPEAT_DELAY_CYC,
    parameter int REPEAT_RATE_CYC  = DEF_REPEAT_RATE_CYC
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic level,
    output logic pulse,
    output logic release_pulse,
    output logic pulse_next
);

    localparam int DW      = cnt_width(DEBOUNCE_CYC);
    localparam int REP_MAX = (REPEAT_DELAY_CYC > REPEAT_RATE_CYC) ? REPEAT_DELAY_CYC : REPEAT_RATE_CYC;
    localparam int RW      = cnt_width(REP_MAX);

    localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE_CYC - 1);
    localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY_CYC - 1);
    localparam logic [RW-1:0] RATE_LAST  = RW'(REPEAT_RATE_CYC - 1);

    logic          sync_meta;
    logic          sync_out;
    logic [DW-1:0] db_cnt;
    logic          accept;
    logic          rise;
    logic          fall;
    btn_state_t    state;
    btn_state_t    state_next;
    logic          release_next;
    logic          rep_clear;
    logic [RW-1:0] rep_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta <= 1'b0;
            sync_out  <= 1'b0;
        end else begin
            sync_meta <= btn;
            sync_out  <= sync_meta;
        end
    end

    assign accept = (sync_out != level) && (db_cnt == DB_LAST);
    assign rise   = accept && !level;
    assign fall   = accept && level;

    // Any cycle of agreement, even a single-cycle glitch, restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_cnt <= '0;
            level  <= 1'b0;
        end else if (accept) begin
            db_cnt <= '0;
            level  <= sync_out;
        end else if (sync_out != level) begin
            db_cnt <= db_cnt + 1'b1;
        end else begin
            db_cnt <= '0;
        end
    end

    // With repeat disabled this register never leaves zero and folds away.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rep_cnt <= '0;
        end else if (REPEAT_EN != 0) begin
            if (rep_clear) begin
                rep_cnt <= '0;
            end else if (state != IDLE) begin
                rep_cnt <= rep_cnt + 1'b1;
            end
        end
    end

    // A release always takes priority over a repeat terminal count.
    always_comb begin
        state_next   = state;
        pulse_next   = 1'b0;
        release_next = 1'b0;
        rep_clear    = 1'b0;
        case (state)
            IDLE: begin
                if (rise) begin
                    state_next = HELD;
                    pulse_next = 1'b1;
                    rep_clear  = 1'b1;
                end
            end
            HELD: begin
                if (fall) begin
                    state_next   = IDLE;
                    release_next = 1'b1;
                end else if ((REPEAT_EN != 0) && (rep_cnt == DELAY_LAST)) begin
                    state_next = REPEAT;
                    pulse_next = 1'b1;
                    rep_clear  = 1'b1;
                end
            end
            REPEAT: begin
                if (fall) begin
                    state_next   = IDLE;
                    release_next = 1'b1;
                end else if (rep_cnt == RATE_LAST) begin
                    pulse_next = 1'b1;
                    rep_clear  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            pulse         <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            state         <= state_next;
            pulse         <= pulse_next;
            release_pulse <= release_next;
        end
    end

endmodule

// File: rtl/btn_pulse_unit.sv
// Push-button conditioning front end: N_BTN independent channels plus a
// combined strobe registered in the same cycle as the per-button pulses.
module btn_pulse_unit
    import btn_pkg::*;
#(
    parameter int N_BTN            = DEF_N_BTN,
    parameter int DEBOUNCE_CYC     = DEF_DEBOUNCE_CYC,
    parameter int REPEAT_EN        = DEF_REPEAT_EN,
    parameter int REPEAT_DELAY_CYC = DEF_REPEAT_DELAY_CYC,
    parameter int REPEAT_RATE_CYC  = DEF_REPEAT_RATE_CYC
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] btn_in,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] pulse,
    output logic [N_BTN-1:0] release_pulse,
    output logic             any_pulse
);

    logic [N_BTN-1:0] pulse_next;

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        btn_channel #(
            .DEBOUNCE_CYC     (DEBOUNCE_CYC),
            .REPEAT_EN        (REPEAT_EN),
            .REPEAT_DELAY_CYC (REPEAT_DELAY_CYC),
            .REPEAT_RATE_CYC  (REPEAT_RATE_CYC)
        ) u_ch (
            .clk           (clk),
            .rst_n         (rst_n),
            .btn           (btn_in[i]),
            .level         (btn_level[i]),
            .pulse         (pulse[i]),
            .release_pulse (release_pulse[i]),
            .pulse_next    (pulse_next[i])
        );
    end

    // Built from the channels' next-pulse terms so it lines up with pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            any_pulse <= 1'b0;
        end else begin
            any_pulse <= |pulse_next;
        end
    end

endmodule

// File: tb/tb_btn_pulse_unit.sv
// Bench for btn_pulse_unit: one instance without and one with auto-repeat,
// both driven by the same buttons and compared against a rule-level model.
module tb_btn_pulse_unit;

    localparam int DEB = 4;
    localparam int RD  = 10;
    localparam int RR  = 3;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] btn_in = 2'b00;

    logic [1:0] lvl_a, pls_a, rel_a, lvl_b, pls_b, rel_b;
    logic       any_a, any_b;

    int checks = 0;
    int errors = 0;

    btn_pulse_unit #(
        .N_BTN(2), .DEBOUNCE_CYC(DEB), .REPEAT_EN(0),
        .REPEAT_DELAY_CYC(RD), .REPEAT_RATE_CYC(RR)
    ) dut_norep (
        .clk(clk), .rst_n(rst_n), .btn_in(btn_in),
        .btn_level(lvl_a), .pulse(pls_a), .release_pulse(rel_a), .any_pulse(any_a)
    );

    btn_pulse_unit #(
        .N_BTN(2), .DEBOUNCE_CYC(DEB), .REPEAT_EN(1),
        .REPEAT_DELAY_CYC(RD), .REPEAT_RATE_CYC(RR)
    ) dut_rep (
        .clk(clk), .rst_n(rst_n), .btn_in(btn_in),
        .btn_level(lvl_b), .pulse(pls_b), .release_pulse(rel_b), .any_pulse(any_b)
    );

    always #5 clk = ~clk;

    // Reference model: inputs seen two edges late, a level flips after DEB
    // consecutive mismatching samples, repeats fall at fixed offsets from the press.
    int         t = 0;
    logic [1:0] ms1 = 2'b00, ms2 = 2'b00, mlvl = 2'b00;
    int         mrun [2] = '{0, 0};
    int         mpress [2] = '{0, 0};
    int         md = 0;
    logic [1:0] ep_a = 2'b00, er_a = 2'b00, ep_b = 2'b00, er_b = 2'b00;

    task automatic model_step();
        if (!rst_n) begin
            ms1 = 2'b00; ms2 = 2'b00; mlvl = 2'b00;
            ep_a = 2'b00; er_a = 2'b00; ep_b = 2'b00; er_b = 2'b00;
            mrun[0] = 0; mrun[1] = 0;
        end else begin
            t++;
            ep_a = 2'b00; er_a = 2'b00; ep_b = 2'b00; er_b = 2'b00;
            for (int c = 0; c < 2; c++) begin
                if (ms2[c] != mlvl[c]) mrun[c]++;
                else mrun[c] = 0;
                if (mrun[c] == DEB) begin
                    mrun[c] = 0;
                    mlvl[c] = ~mlvl[c];
                    if (mlvl[c]) begin
                        ep_a[c] = 1'b1; ep_b[c] = 1'b1; mpress[c] = t;
                    end else begin
                        er_a[c] = 1'b1; er_b[c] = 1'b1;
                    end
                end else if (mlvl[c]) begin
                    md = t - mpress[c];
                    if (md == RD || (md > RD && (md - RD) % RR == 0)) ep_b[c] = 1'b1;
                end
            end
            ms2 = ms1;
            ms1 = btn_in;
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            model_step();
        end
    end

    function automatic logic [13:0] obs();
        return {lvl_a, pls_a, rel_a, any_a, lvl_b, pls_b, rel_b, any_b};
    endfunction

    function automatic logic [13:0] exp_vec();
        return {mlvl, ep_a, er_a, |ep_a, mlvl, ep_b, er_b, |ep_b};
    endfunction

    task automatic test_reset();
        rst_n  = 1'b0;
        btn_in = 2'b00;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (obs() !== 14'd0) begin
                errors++;
                $display("[TB] FAIL reset_outputs cyc=%0d got=%b want=%b", k, obs(), 14'd0);
            end
        end
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (obs() !== exp_vec()) begin
                errors++;
                $display("[TB] FAIL reset_model cyc=%0d got=%b want=%b", k, obs(), exp_vec());
            end
        end
    endtask

    task automatic test_press();
        int first = -1;
        int npulse = 0;
        int nany = 0;
        btn_in = 2'b01;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            checks++;
            if (obs() !== exp_vec()) begin
                errors++;
                $display("[TB] FAIL press_model cyc=%0d got=%b want=%b", k, obs(), exp_vec());
            end
            if (pls_a[0]) begin
                npulse++;
                if (first < 0) first = k;
            end
            if (any_a) nany++;
        end
        checks++;
        if (first != DEB + 1) begin
            errors++;
            $display("[TB] FAIL press_latency got=%0d want=%0d", first, DEB + 1);
        end
        checks++;
        if (npulse != 1) begin
            errors++;
            $display("[TB] FAIL press_pulse_count got=%0d want=1", npulse);
        end
        checks++;
        if (nany != 1) begin
            errors++;
            $display("[TB] FAIL press_any_count got=%0d want=1", nany);
        end
        btn_in = 2'b00;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            checks++;
            if (obs() !== exp_vec()) begin
                errors++;
                $display("[TB] FAIL press_release_model cyc=%0d got=%b want=%b", k, obs(), exp_vec());
            end
        end
    endtask

    task automatic test_glitch();
        int bad = 0;
        int first_rel = -1;
        btn_in = 2'b01;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            checks++;
            if (obs() !== exp_vec()) begin
                errors++;
                $display("[TB] FAIL glitch_press_model cyc=%0d got=%b want=%b", k, obs(), exp_vec());
            end
            if (lvl_a[0] || pls_a[0]) bad++;
            if (k == 2) btn_in = 2'b00;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("[TB] FAIL glitch_no_press got=%0d want=0", bad);
        end
        btn_in = 2'b01;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            checks++;
            if (obs() !== exp_vec()) begin
                errors++;
                $display("[TB] FAIL glitch_hold_model cyc=%0d got=%b want=%b", k, obs(), exp_vec());
            end
        end
        btn_in = 2'b00;
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            checks++;
            if (obs() !== exp_vec()) begin
                errors++;
                $display("[TB] FAIL glitch_release_model cyc=%0d got=%b want=%b", k, obs(), exp_vec());
            end
            if (rel_a[0] && first_rel < 0) first_rel = k;
            if (k == 1) btn_in = 2'b01;
            if (k == 2) btn_in = 2'b00;
        end
        checks++;
        if (first_rel != 8) begin
            errors++;
            $display("[TB] FAIL glitch_release_delay got=%0d want=8", first_rel);
        end
    endtask

    task automatic test_repeat();
        int exp_p [9] = '{0, 10, 13, 16, 19, 22, 25, 28, 31};
        int q_p [$];
        int q_r [$];
        bit found = 1'b0;
        btn_in = 2'b10;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clk);
            checks++;
            if (obs() !== exp_vec()) begin
                errors++;
                $display("[TB] FAIL repeat_model cyc=%0d got=%b want=%b", k, obs(), exp_vec());
            end
            if (pls_b[1]) begin
                found = 1'b1;
                q_p.push_back(0);
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("[TB] FAIL repeat_press_timeout got=none want=pulse");
        end else begin
            for (int off = 1; off <= 40; off++) begin
                @(negedge clk);
                checks++;
                if (obs() !== exp_vec()) begin
                    errors++;
                    $display("[TB] FAIL repeat_model off=%0d got=%b want=%b", off, obs(), exp_vec());
                end
                if (pls_b[1]) q_p.push_back(off);
                if (rel_b[1]) q_r.push_back(off);
                if (off == 28) btn_in = 2'b00;
            end
            checks++;
            if (q_p.size() != 9) begin
                errors++;
                $display("[TB] FAIL repeat_pulse_count got=%0d want=9", q_p.size());
            end
            for (int i = 0; i < 9 && i < q_p.size(); i++) begin
                checks++;
                if (q_p[i] != exp_p[i]) begin
                    errors++;
                    $display("[TB] FAIL repeat_offset idx=%0d got=%0d want=%0d", i, q_p[i], exp_p[i]);
                end
            end
            checks++;
            if (q_r.size() != 1 || q_r[0] != 34) begin
                errors++;
                $display("[TB] FAIL repeat_release got_n=%0d got_first=%0d want=34",
                         q_r.size(), (q_r.size() > 0) ? q_r[0] : -1);
            end
        end
    endtask

    task automatic test_simul();
        int both = 0;
        int single = 0;
        int nany = 0;
        btn_in = 2'b11;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            checks++;
            if (obs() !== exp_vec()) begin
                errors++;
                $display("[TB] FAIL simul_model cyc=%0d got=%b want=%b", k, obs(), exp_vec());
            end
            if (pls_a == 2'b11) both++;
            if (pls_a == 2'b01 || pls_a == 2'b10) single++;
            if (any_a) nany++;
        end
        checks++;
        if (both != 1 || single != 0) begin
            errors++;
            $display("[TB] FAIL simul_pulses got_both=%0d got_single=%0d want=1,0", both, single);
        end
        checks++;
        if (nany != 1) begin
            errors++;
            $display("[TB] FAIL simul_any got=%0d want=1", nany);
        end
        btn_in = 2'b00;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            checks++;
            if (obs() !== exp_vec()) begin
                errors++;
                $display("[TB] FAIL simul_release_model cyc=%0d got=%b want=%b", k, obs(), exp_vec());
            end
        end
    endtask

    task automatic test_reset_mid();
        int first = -1;
        btn_in = 2'b01;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            checks++;
            if (obs() !== exp_vec()) begin
                errors++;
                $display("[TB] FAIL rstmid_hold_model cyc=%0d got=%b want=%b", k, obs(), exp_vec());
            end
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs() !== 14'd0) begin
            errors++;
            $display("[TB] FAIL rstmid_async_clear got=%b want=%b", obs(), 14'd0);
        end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checks++;
            if (obs() !== 14'd0) begin
                errors++;
                $display("[TB] FAIL rstmid_held_clear cyc=%0d got=%b want=%b", k, obs(), 14'd0);
            end
        end
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            checks++;
            if (obs() !== exp_vec()) begin
                errors++;
                $display("[TB] FAIL rstmid_repress_model cyc=%0d got=%b want=%b", k, obs(), exp_vec());
            end
            if (pls_a[0] && first < 0) first = k;
        end
        checks++;
        if (first != DEB + 1) begin
            errors++;
            $display("[TB] FAIL rstmid_repress_latency got=%0d want=%0d", first, DEB + 1);
        end
        btn_in = 2'b00;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            checks++;
            if (obs() !== exp_vec()) begin
                errors++;
                $display("[TB] FAIL rstmid_release_model cyc=%0d got=%b want=%b", k, obs(), exp_vec());
            end
        end
    endtask

    task automatic test_random();
        int npress = 0;
        int nrel = 0;
        int bad = 0;
        bit last_press = 1'b0;
        for (int ph = 0; ph < 41; ph++) begin
            int gap;
            gap = (ph == 40) ? 14 : int'($urandom_range(12, 6));
            btn_in[0] = (ph % 2 == 0) && (ph < 40);
            for (int k = 0; k < gap; k++) begin
                if ($urandom_range(4, 0) == 0) btn_in[1] = ~btn_in[1];
                @(negedge clk);
                checks++;
                if (obs() !== exp_vec()) begin
                    errors++;
                    $display("[TB] FAIL random_model ph=%0d cyc=%0d got=%b want=%b", ph, k, obs(), exp_vec());
                end
                if (pls_a[0] && rel_a[0]) bad++;
                if (pls_a[0]) begin
                    if (last_press) bad++;
                    last_press = 1'b1;
                    npress++;
                end
                if (rel_a[0]) begin
                    if (!last_press) bad++;
                    last_press = 1'b0;
                    nrel++;
                end
            end
        end
        checks++;
        if (npress != 20 || nrel != 20) begin
            errors++;
            $display("[TB] FAIL random_counts got_press=%0d got_rel=%0d want=20,20", npress, nrel);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("[TB] FAIL random_alternation got=%0d want=0", bad);
        end
    endtask

    initial begin
        test_reset();
        test_press();
        test_glitch();
        test_repeat();
        test_simul();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
